// File: rtl/vga_maze_render.sv
// Two-stage tile-map pixel renderer: a 20x15 map of 32x32 tiles plus a player marker,
// with syncs and frame-start pulse delayed to line up with the colour outputs.
module vga_maze_render #(
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter logic [11:0] C_FLOOR  = 12'h000,
  parameter logic [11:0] C_WALL   = 12'h00F,
  parameter logic [11:0] C_GOAL   = 12'h0F0,
  parameter logic [11:0] C_START  = 12'hFF0,
  parameter logic [11:0] C_PLAYER = 12'hF00
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [10:0] i_HPos,
  input  logic [10:0] i_VPos,
  input  logic        i_HSync,
  input  logic        i_VSync,
  input  logic        i_WrEn,
  input  logic [8:0]  i_WrAddr,
  input  logic [1:0]  i_WrData,
  input  logic [4:0]  i_PlayerX,
  input  logic [3:0]  i_PlayerY,
  output logic        o_HSync,
  output logic        o_VSync,
  output logic [3:0]  o_Red,
  output logic [3:0]  o_Grn,
  output logic [3:0]  o_Blu,
  output logic        o_FrameStart
);

  localparam int TILES = 300;

  // Tile map kept as a flat vector so reset can clear it in one assignment.
  logic [2*TILES-1:0] map_bits;
  logic [4:0]         shadow_x;
  logic [3:0]         shadow_y;

  logic        frame_edge;
  logic        active;
  logic [4:0]  tile_col;
  logic [3:0]  tile_row;
  logic [8:0]  tile_idx;
  logic [1:0]  tile_rd;
  logic        player_hit;

  logic        s1_active;
  logic [1:0]  s1_tile;
  logic        s1_player;
  logic        s1_hsync;
  logic        s1_vsync;
  logic        s1_frame;

  logic [11:0] pixel_next;
  logic [11:0] pixel;

  function automatic logic in_band(input logic [4:0] off);
    return (off >= 5'd8) && (off <= 5'd23);
  endfunction

  always_comb begin
    frame_edge = (i_HPos == 11'd0) && (i_VPos == 11'(V_ACTIVE));
    active     = (i_HPos < 11'(H_ACTIVE)) && (i_VPos < 11'(V_ACTIVE));
    tile_col   = i_HPos[9:5];
    tile_row   = i_VPos[8:5];
    tile_idx   = 9'(tile_row) * 9'd20 + 9'(tile_col);
    tile_rd    = 2'd0;
    // Blanking positions can index past the map; those reads are never shown.
    if (tile_idx < 9'(TILES))
      tile_rd = map_bits[{tile_idx, 1'b0} +: 2];
    player_hit = (tile_col == shadow_x) && (tile_row == shadow_y) &&
                 (shadow_x < 5'd20) && (shadow_y < 4'd15) &&
                 in_band(i_HPos[4:0]) && in_band(i_VPos[4:0]);
  end

  // Map write lands on the same edge that stage 1 samples the old entry.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      map_bits <= '0;
    end else if (i_WrEn && (i_WrAddr < 9'(TILES))) begin
      map_bits[{i_WrAddr, 1'b0} +: 2] <= i_WrData;
    end
  end

  // Player position only moves during vertical blanking so frames never tear.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      shadow_x <= 5'd31;
      shadow_y <= 4'd15;
    end else if (frame_edge) begin
      shadow_x <= i_PlayerX;
      shadow_y <= i_PlayerY;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      s1_active <= 1'b0;
      s1_tile   <= 2'd0;
      s1_player <= 1'b0;
      s1_hsync  <= 1'b1;
      s1_vsync  <= 1'b1;
      s1_frame  <= 1'b0;
    end else begin
      s1_active <= active;
      s1_tile   <= tile_rd;
      s1_player <= player_hit;
      s1_hsync  <= i_HSync;
      s1_vsync  <= i_VSync;
      s1_frame  <= frame_edge;
    end
  end

  always_comb begin
    pixel_next = 12'h000;
    if (s1_active) begin
      if (s1_player) begin
        pixel_next = C_PLAYER;
      end else begin
        case (s1_tile)
          2'd0:    pixel_next = C_FLOOR;
          2'd1:    pixel_next = C_WALL;
          2'd2:    pixel_next = C_GOAL;
          default: pixel_next = C_START;
        endcase
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      pixel        <= 12'h000;
      o_HSync      <= 1'b1;
      o_VSync      <= 1'b1;
      o_FrameStart <= 1'b0;
    end else begin
      pixel        <= pixel_next;
      o_HSync      <= s1_hsync;
      o_VSync      <= s1_vsync;
      o_FrameStart <= s1_frame;
    end
  end

  assign o_Red = pixel[11:8];
  assign o_Grn = pixel[7:4];
  assign o_Blu = pixel[3:0];

endmodule

// File: doc/vga_maze_render.md
VGA_MAZE_RENDER -- requirements
Module: vga_maze_render

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 SHALL have parameter C_FLOOR, default 12'h000, floor colour (RGB 4:4:4).
REQ-004 SHALL have parameter C_WALL, default 12'h00F, wall colour.
REQ-005 SHALL have parameter C_GOAL, default 12'h0F0, goal colour.
REQ-006 SHALL have parameter C_START, default 12'hFF0, start colour.
REQ-007 SHALL have parameter C_PLAYER, default 12'hF00, player colour.
REQ-008 SHALL have: i_Clk  input  1  sole clock.
REQ-009 SHALL have: i_Rst  input  1  reset, asynchronous, active-high.
REQ-010 SHALL have: i_HPos  input  11  horizontal pixel counter, 0..799.
REQ-011 SHALL have: i_VPos  input  11  vertical line counter, 0..524.
REQ-012 SHALL have: i_HSync / i_VSync  input  1 each  sync from timing generator, aligned with i_HPos/i_VPos.
REQ-013 SHALL have: i_WrEn  input  1  tile-map write strobe.
REQ-014 SHALL have: i_WrAddr  input  9  tile index, row*20+col, valid 0..299.
REQ-015 SHALL have: i_WrData  input  2  tile type: 0 floor, 1 wall, 2 goal, 3 start.
REQ-016 SHALL have: i_PlayerX  input  5  player tile column 0..19; i_PlayerY  input  4  player tile row 0..14.
REQ-017 SHALL have: o_HSync / o_VSync  output  1 each  syncs delayed to match pixels.
REQ-018 SHALL have: o_Red / o_Grn / o_Blu  output  4 each  pixel colour.
REQ-019 SHALL have: o_FrameStart  output  1  one-cycle pulse at start of vertical blanking.

Function
REQ-020 SHALL hold a 300-entry x 2-bit tile map, 20 cols x 15 rows, 32x32-pixel tiles.
REQ-021 SHALL write i_WrData to entry i_WrAddr on rising edge when i_WrEn=1; i_WrAddr>=300 ignored, no entry changes.
REQ-022 SHALL use read-before-write: a pixel read of the entry written in the same cycle returns the old value.
REQ-023 SHALL pipeline in 2 stages; o_HSync, o_VSync, RGB appear exactly 2 cycles after corresponding i_HPos/i_VPos/i_HSync/i_VSync.
REQ-024 Stage 1 SHALL register active = (i_HPos<H_ACTIVE && i_VPos<V_ACTIVE), tile index = i_VPos[8:5]*20 + i_HPos[9:5], in-tile offsets i_HPos[4:0], i_VPos[4:0], player-tile match, syncs.
REQ-025 Stage 2 SHALL register colour: inactive -> 12'h000; else player pixel -> C_PLAYER; else tile-type colour.
REQ-026 Player pixel SHALL be: tile column = latched X, tile row = latched Y, both in-tile offsets within 8..23 inclusive.
REQ-027 SHALL latch i_PlayerX/i_PlayerY into shadow registers only when i_HPos==0 && i_VPos==V_ACTIVE; position changes never tear mid-frame.
REQ-028 o_FrameStart SHALL pulse for one cycle 2 cycles after i_HPos==0 && i_VPos==V_ACTIVE, aligned with the shadow update being in effect.
REQ-029 Latched player coordinates out of range (X>19 or Y>14) SHALL draw no player.
REQ-030 i_HPos 640..799 and i_VPos 480..524 SHALL always yield black, independent of tile contents.
REQ-031 Pixels at i_HPos 639 and 0 of consecutive lines SHALL be rendered with no bubble; pipeline runs every cycle, no stall.

Reset
REQ-032 On i_Rst=1, immediately and asynchronously: RGB 0, o_HSync=1, o_VSync=1, o_FrameStart=0, pipeline registers cleared, all tile entries 0 (floor), shadow player X=31, Y=15 (no player drawn).
REQ-033 Reset asserted mid-frame SHALL abort in-flight pixels; first valid output appears 2 cycles after first clock edge following deassertion.
REQ-034 Writes with i_Rst=1 SHALL be ignored.

Verification
REQ-035 After reset, sweep a full frame, no writes -> all RGB 0 everywhere; syncs equal inputs delayed 2 cycles.
REQ-036 Write entry 21 = wall (1) -> pixels HPos 32..63, VPos 32..63 show 12'h00F at 2-cycle latency; neighbours 12'h000.
REQ-037 PlayerX=3, PlayerY=2 set mid-frame -> unchanged until next frame; after o_FrameStart, HPos 104..119, VPos 72..87 red; rest of tile 2*20+3 shows its tile colour.
REQ-038 Write addr 300 with data 3 -> no tile changes; write addr 299 = goal -> HPos 608..639, VPos 448..479 green; HPos 640 black.
REQ-039 Write entry 0 in cycle HPos=0, VPos=0 -> that pixel shows old floor colour; next frame shows new colour.
REQ-040 Assert i_Rst at HPos=300, VPos=200 -> outputs immediately RGB 0, syncs 1; map cleared; rendering resumes 2 cycles after release.
